iir_shift: RTL and testbench

- All-pole recursive (IIR) synthesis filter: the feedback counterpart of the team's shift-coefficient FIR.
- Computes y[n] = sat( x[n] + (y[n-1]>>SH1) + (y[n-2]>>SH2) + (y[n-3]>>SH3) + (y[n-4]>>SH4) ).
- Evaluated serially, one feedback tap per cycle, through a single adder.
- Valid/ready handshakes on input and output so it can sit between streaming blocks in the filter chain.

---
 rtl/iir_shift.sv | 117 +++++++++++
 tb/tb_iir_shift.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/iir_shift.sv
// iir_shift: all-pole recursive synthesis filter with shift-only feedback taps.
// y[n] = sat(x[n] + sum_k (y[n-k] >> SHk)), k = 1..4, one tap per cycle via one adder.
// Valid/ready handshakes on both sides; a new sample is taken only from IDLE.
module iir_shift #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OW  = 10,
  parameter int unsigned SH1 = 1,
  parameter int unsigned SH2 = 2,
  parameter int unsigned SH3 = 3,
  parameter int unsigned SH4 = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] x,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int unsigned AW = OW + 2;
  localparam logic [AW-1:0] SAT_MAX = {2'b00, {OW{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t        state_q;
  logic [AW-1:0] acc_q;
  logic [2:0]    k_q;
  logic [OW-1:0] y1_q, y2_q, y3_q, y4_q;
  logic [OW-1:0] y_q;
  logic          in_ready_q, out_valid_q, busy_q;

  logic [OW-1:0] tap_c;
  logic [AW-1:0] sum_c;
  logic [OW-1:0] sat_c;

  assign y         = y_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  // Select and shift the feedback tap for the current step, then add and clamp.
  always_comb begin
    tap_c = '0;
    unique case (k_q)
      3'd1:    tap_c = y1_q >> SH1;
      3'd2:    tap_c = y2_q >> SH2;
      3'd3:    tap_c = y3_q >> SH3;
      default: tap_c = y4_q >> SH4;
    endcase
    sum_c = acc_q + AW'(tap_c);
    sat_c = (sum_c > SAT_MAX) ? {OW{1'b1}} : sum_c[OW-1:0];
  end

  // Control FSM, accumulator, delay line and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      y3_q        <= '0;
      y4_q        <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_q      <= AW'(x);
            k_q        <= 3'd1;
            state_q    <= ACC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ACC: begin
          if (k_q == 3'd4) begin
            // Last tap: publish the clamped result and advance the delay line.
            y_q         <= sat_c;
            y4_q        <= y3_q;
            y3_q        <= y2_q;
            y2_q        <= y1_q;
            y1_q        <= sat_c;
            acc_q       <= sum_c;
            k_q         <= '0;
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end else begin
            acc_q <= sum_c;
            k_q   <= k_q + 3'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_shift.sv
// Bench for iir_shift: scoreboard of model results against output handshakes,
// plus directed latency, backpressure, saturation and mid-operation reset checks.
module tb_iir_shift;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] x;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] y;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int got_q[$];
  int mdl1, mdl2, mdl3, mdl4;

  iir_shift dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference filter: advances its own delay line on each accepted sample.
  function automatic int model_step(input int xv);
    int s;
    s = xv + (mdl1 >> 1) + (mdl2 >> 2) + (mdl3 >> 3) + (mdl4 >> 4);
    if (s > 1023) s = 1023;
    mdl4 = mdl3; mdl3 = mdl2; mdl2 = mdl1; mdl1 = s;
    return s;
  endfunction

  // Scoreboard monitor, sampled on the falling edge between active edges.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mdl1 = 0; mdl2 = 0; mdl3 = 0; mdl4 = 0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model_step(int'(x)));
      if (out_valid && out_ready) begin
        got_q.push_back(int'(y));
        if (exp_q.size() == 0) check("spurious_out", int'(y), -1);
        else check("sb_y", int'(y), exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Present one sample and hold it until it is accepted (bounded).
  task automatic send(input int v);
    int n = 0;
    x = 8'(v); in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int c = 0;
    while (got_q.size() < n && c < 500) begin
      @(posedge clk);
      c++;
    end
    if (c >= 500) check("out_timeout", got_q.size(), n);
    #1;
  endtask

  initial begin
    int imp_exp[6];
    int sat_exp[5];
    int rv;
    imp_exp = '{128, 64, 64, 64, 64, 60};
    sat_exp = '{255, 382, 509, 635, 761};
    rst = 1'b1; x = '0; in_valid = 1'b0; out_ready = 1'b1;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_y", int'(y), 0);
    @(posedge clk); #1;

    // Impulse response
    got_q.delete();
    send(128);
    for (int i = 0; i < 5; i++) send(0);
    wait_outs(6);
    for (int i = 0; i < 6; i++) check($sformatf("impulse_%0d", i), got_q[i], imp_exp[i]);

    // Saturation with constant full-scale input
    do_reset();
    got_q.delete();
    for (int i = 0; i < 12; i++) send(255);
    wait_outs(12);
    for (int i = 0; i < 5; i++) check($sformatf("sat_%0d", i), got_q[i], sat_exp[i]);
    for (int i = 8; i < 12; i++) check($sformatf("sat_hold_%0d", i), got_q[i], 1023);

    // Latency and handshake from a zero delay line
    do_reset();
    got_q.delete();
    x = 8'd10; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;                     // edge N accepts
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_in_ready_n", int'(in_ready), 0);
    check("lat_busy_n", int'(busy), 1);
    check("lat_ov_n", int'(out_valid), 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("lat_ov_n%0d", i), int'(out_valid), 0);
      check($sformatf("lat_ir_n%0d", i), int'(in_ready), 0);
    end
    @(negedge clk);
    check("lat_ov_n4", int'(out_valid), 1);
    check("lat_y_n4", int'(y), 10);

    // Backpressure: stall in OUT while a new sample is offered
    @(posedge clk); #1;
    x = 8'd77; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_y", int'(y), 10);
      check("bp_ov", int'(out_valid), 1);
      check("bp_ir", int'(in_ready), 0);
      check("bp_busy", int'(busy), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;                     // handshake edge
    @(negedge clk);
    check("bp_release_ov", int'(out_valid), 0);
    check("bp_release_ir", int'(in_ready), 1);
    @(posedge clk); #1;
    send(77);
    wait_outs(2);
    check("bp_first", got_q[0], 10);
    check("bp_next", got_q[1], 82);

    // Random stream through the scoreboard
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      rv = int'($urandom_range(0, 255));
      send(rv);
    end
    wait_outs(20);

    // Reset during ACC cycle 2 after three nonzero outputs
    do_reset();
    got_q.delete();
    for (int i = 0; i < 3; i++) send(50);
    wait_outs(3);
    x = 8'd100; in_valid = 1'b1;
    @(negedge clk);
    check("mid_accept_ready", int'(in_ready), 1);
    @(posedge clk); #1;                     // edge N accepts
    in_valid = 1'b0;
    @(posedge clk); #1;                     // edge N+1, now in ACC cycle 2
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid_no_ov", int'(out_valid), 0);
    end
    check("mid_outs", got_q.size(), 3);
    check("mid_y_cleared", int'(y), 0);
    @(posedge clk); #1;
    got_q.delete();
    send(128); send(0); send(0);
    wait_outs(3);
    for (int i = 0; i < 3; i++) check($sformatf("post_rst_%0d", i), got_q[i], imp_exp[i]);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
